// File: rtl/xor_gate_module.sv
// Bitwise XOR gate with zero-latency output, a registered copy, a running
// parity accumulator and a saturating mismatch counter.
module xor_gate_module #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] x_q,
   output logic             par,
   output logic [CNT_W-1:0] mis_cnt
);

   logic [WIDTH-1:0] xq_q, xq_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign x = a ^ b;

   always_comb begin
      xq_d  = xq_q;
      par_d = par_q;
      cnt_d = cnt_q;
      if (en) begin
         xq_d  = a ^ b;
         par_d = par_q ^ (^(a ^ b));
         // Saturate at all-ones instead of wrapping.
         if ((a != b) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xq_q  <= '0;
         par_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         xq_q  <= xq_d;
         par_q <= par_d;
         cnt_q <= cnt_d;
      end
   end

   assign x_q     = xq_q;
   assign par     = par_q;
   assign mis_cnt = cnt_q;

endmodule

// File: tb/tb_xor_gate_module.sv
// Self-checking bench: three instances (default, 2-bit counter, 4-bit wide)
// checked against a counting reference model plus directed vectors.
module tb_xor_gate_module;

   logic       clk = 1'b0;
   logic       rst, en;
   logic       a1, b1;
   logic [3:0] a4, b4;

   logic       x1, xq1, par1;
   logic [7:0] cnt1;
   logic       x2, xq2, par2;
   logic [1:0] cnt2;
   logic [3:0] x4, xq4;
   logic       par4;
   logic [7:0] cnt4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xor_gate_module u1 (
      .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1),
      .x(x1), .x_q(xq1), .par(par1), .mis_cnt(cnt1)
   );

   xor_gate_module #(.WIDTH(1), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1),
      .x(x2), .x_q(xq2), .par(par2), .mis_cnt(cnt2)
   );

   xor_gate_module #(.WIDTH(4), .CNT_W(8)) u4 (
      .clk(clk), .rst(rst), .en(en), .a(a4), .b(b4),
      .x(x4), .x_q(xq4), .par(par4), .mis_cnt(cnt4)
   );

   // Reference model: keep totals of sampled one-bits and mismatching cycles;
   // parity and saturated count are derived from those totals.
   int         ones1, mis1, ones4, mis4;
   logic       exq1;
   logic [3:0] exq4;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ones1 = 0; mis1 = 0; ones4 = 0; mis4 = 0;
         exq1 = 1'b0; exq4 = 4'd0;
      end else if (en) begin
         exq1  = (a1 != b1);
         ones1 = ones1 + ((a1 != b1) ? 1 : 0);
         mis1  = mis1 + ((a1 != b1) ? 1 : 0);
         for (int i = 0; i < 4; i++) begin
            exq4[i] = (a4[i] != b4[i]);
            ones4   = ones4 + ((a4[i] != b4[i]) ? 1 : 0);
         end
         mis4 = mis4 + ((a4 != b4) ? 1 : 0);
      end
   end

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [3:0] ex4;
      for (int i = 0; i < 4; i++) ex4[i] = (a4[i] != b4[i]);
      check("u1.x", x1, (a1 != b1));
      check("u1.x_q", xq1, exq1);
      check("u1.par", par1, ones1 % 2);
      check("u1.mis_cnt", cnt1, sat(mis1, 255));
      check("u2.x_q", xq2, exq1);
      check("u2.par", par2, ones1 % 2);
      check("u2.mis_cnt", cnt2, sat(mis1, 3));
      check("u4.x", x4, ex4);
      check("u4.x_q", xq4, exq4);
      check("u4.par", par4, ones4 % 2);
      check("u4.mis_cnt", cnt4, sat(mis4, 255));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   typedef struct {
      logic a;
      logic b;
      logic x;
   } tt_vec_t;

   typedef struct {
      logic [1:0] cnt;
      logic       par;
   } sat_vec_t;

   tt_vec_t  tt  [4];
   sat_vec_t sv  [5];

   initial begin
      tt[0] = '{1'b0, 1'b0, 1'b0};
      tt[1] = '{1'b0, 1'b1, 1'b1};
      tt[2] = '{1'b1, 1'b0, 1'b1};
      tt[3] = '{1'b1, 1'b1, 1'b0};
      sv[0] = '{2'd1, 1'b1};
      sv[1] = '{2'd2, 1'b0};
      sv[2] = '{2'd3, 1'b1};
      sv[3] = '{2'd3, 1'b0};
      sv[4] = '{2'd3, 1'b1};

      rst = 1'b1; en = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      #1;
      check("reset x_q", xq1, 1'b0);
      check("reset par", par1, 1'b0);
      check("reset mis_cnt", cnt1, 8'd0);

      // Combinational truth table while held in reset (x must still track)
      for (int i = 0; i < 4; i++) begin
         a1 = tt[i].a; b1 = tt[i].b;
         #10;
         check("truth x", x1, tt[i].x);
         check("truth x u2", x2, tt[i].x);
      end
      a4 = 4'b1010; b4 = 4'b0110;
      #1;
      check("wide x", x4, 4'b1100);

      // Registered path
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1; a1 = 1'b1; b1 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      step();
      check("reg1 x_q", xq1, 1'b1);
      check("reg1 par", par1, 1'b1);
      check("reg1 cnt", cnt1, 8'd1);
      a1 = 1'b1; b1 = 1'b1;
      step();
      check("reg2 x_q", xq1, 1'b0);
      check("reg2 par", par1, 1'b1);
      check("reg2 cnt", cnt1, 8'd1);

      // Load x_q=1, par=1, mis_cnt=3 then reset between edges
      a1 = 1'b0; b1 = 1'b1;
      step();
      a1 = 1'b1; b1 = 1'b0;
      step();
      check("load x_q", xq1, 1'b1);
      check("load par", par1, 1'b1);
      check("load cnt", cnt1, 8'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async x_q", xq1, 1'b0);
      check("async par", par1, 1'b0);
      check("async cnt", cnt1, 8'd0);
      check("async x", x1, 1'b1);
      check_all();
      @(posedge clk); #1;
      rst = 1'b0;

      // Enable hold
      en = 1'b0; a1 = 1'b0; b1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold x_q", xq1, 1'b0);
         check("hold cnt", cnt1, 8'd0);
         check("hold x", x1, 1'b1);
      end

      // Saturation on the 2-bit counter
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("sat cnt", cnt2, sv[i].cnt);
         check("sat par", par2, sv[i].par);
      end

      // Wide operands through the registered path
      a4 = 4'b1010; b4 = 4'b0110;
      begin
         logic p0;
         logic [7:0] c0;
         p0 = par4; c0 = cnt4;
         step();
         check("wide x_q", xq4, 4'b1100);
         check("wide par", par4, p0);
         check("wide cnt", cnt4, c0 + 8'd1);
      end

      // Randomized stimulus with occasional reset pulses
      for (int i = 0; i < 300; i++) begin
         a1  = 1'($urandom);
         b1  = 1'($urandom);
         a4  = 4'($urandom);
         b4  = 4'($urandom);
         en  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 29) == 0);
         #1;
         check_all();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
